renkon_pool_maxn: RTL

//  Streaming max-pooling unit for the renkon conv engine. Generalises the fixed
//  4-input, single-channel max pool to LANES parallel channels and a runtime

---
 rtl/renkon_pool_maxn.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/renkon_pool_maxn.sv
// ---------------------------------------------------------------------------
// renkon_pool_maxn
//   Streaming max-pooling unit for the renkon conv engine. Each of LANES
//   channels keeps a running signed maximum over a window of 1..WMAX samples.
//   An optional ReLU clamps negative results to zero. One finished window per
//   lane is presented on out_data together with a one-cycle out_valid strobe.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       synchronous abort of the current window (wins over in_valid)
//   win_len   samples per window, sampled on the first sample of a window
//   relu_en   clamp negative results to 0, sampled with win_len
//   in_valid  in_data carries one sample per lane this cycle
//   in_data   lane k in bits [k*DWIDTH +: DWIDTH], two's complement
//   busy      high while a window is partially accumulated
//   out_valid one-cycle strobe, out_data holds a finished window
//   out_data  per-lane pooled result, held until the next emit
// ---------------------------------------------------------------------------
module renkon_pool_maxn #(
  parameter int DWIDTH = 16,
  parameter int LANES  = 4,
  parameter int WMAX   = 16,
  parameter int CNTW   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [CNTW-1:0]         win_len,
  input  logic                    relu_en,
  input  logic                    in_valid,
  input  logic [LANES*DWIDTH-1:0] in_data,
  output logic                    busy,
  output logic                    out_valid,
  output logic [LANES*DWIDTH-1:0] out_data
);

  // Clamp a requested window length into 1..WMAX.
  function automatic logic [CNTW-1:0] eff_len(input logic [CNTW-1:0] w);
    if (w == {CNTW{1'b0}}) begin
      return CNTW'(1);
    end else if (w > CNTW'(WMAX)) begin
      return CNTW'(WMAX);
    end else begin
      return w;
    end
  endfunction

  // Signed maximum of two samples.
  function automatic logic [DWIDTH-1:0] smax(input logic [DWIDTH-1:0] a,
                                             input logic [DWIDTH-1:0] b);
    if ($signed(a) > $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [CNTW-1:0]         len_q, len_d;
  logic                    relu_q, relu_d;
  logic [LANES*DWIDTH-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DWIDTH-1:0] out_data_q, out_data_d;

  logic                    idle_s;
  logic [CNTW-1:0]         len_s;
  logic                    relu_s;
  logic                    last_s;
  logic [LANES*DWIDTH-1:0] mx_s;
  logic [LANES*DWIDTH-1:0] res_s;

  // Per-lane datapath: running max including the current sample, then ReLU.
  // In IDLE the current sample opens the window, so the live win_len/relu_en
  // are used; otherwise the values latched at window start apply.
  always_comb begin
    idle_s = (cnt_q == {CNTW{1'b0}});
    len_s  = idle_s ? eff_len(win_len) : len_q;
    relu_s = idle_s ? relu_en : relu_q;
    if (idle_s) begin
      last_s = (len_s == CNTW'(1));
    end else begin
      last_s = ((cnt_q + CNTW'(1)) == len_q);
    end
    mx_s  = {LANES*DWIDTH{1'b0}};
    res_s = {LANES*DWIDTH{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (idle_s) begin
        mx_s[k*DWIDTH +: DWIDTH] = in_data[k*DWIDTH +: DWIDTH];
      end else begin
        mx_s[k*DWIDTH +: DWIDTH] = smax(acc_q[k*DWIDTH +: DWIDTH],
                                        in_data[k*DWIDTH +: DWIDTH]);
      end
      if (relu_s && mx_s[k*DWIDTH + DWIDTH - 1]) begin
        res_s[k*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
      end else begin
        res_s[k*DWIDTH +: DWIDTH] = mx_s[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // Next-state logic: clr aborts, a valid sample advances the window.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clr) begin
      cnt_d  = {CNTW{1'b0}};
      busy_d = 1'b0;
    end else if (in_valid) begin
      acc_d  = mx_s;
      len_d  = len_s;
      relu_d = relu_s;
      if (last_s) begin
        cnt_d       = {CNTW{1'b0}};
        busy_d      = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = res_s;
      end else begin
        cnt_d  = cnt_q + CNTW'(1);
        busy_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= {CNTW{1'b0}};
      len_q       <= CNTW'(1);
      relu_q      <= 1'b0;
      acc_q       <= {LANES*DWIDTH{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {LANES*DWIDTH{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
